// File: rtl/hydra_pkg.sv
// Shared types and constants for the hydra ingress/egress datapath.
package hydra_pkg;

    localparam int unsigned NUM_PORTS = 16;
    localparam int unsigned DATA_W    = 128;
    localparam int unsigned MAX_WORDS = 64;
    localparam int unsigned IDX_W     = $clog2(MAX_WORDS);

    typedef logic [3:0]       port_id_t;
    typedef logic [2:0]       prior_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE,
        LOCKED
    } arb_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        port_id_t          src;
        port_id_t          dest;
        prior_t            prior;
        logic              last;
        idx_t              idx;
    } out_word_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: first set bit of req_i scanning upward from ptr_i, wrapping.
module rr_pick #(
    parameter int unsigned N = 16,
    parameter int unsigned W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic         found_o,
    output logic [W-1:0] idx_o
);

    logic [W-1:0] cand;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        // N is a power of two, so the W-bit sum wraps exactly at N.
        for (int unsigned i = 0; i < N; i++) begin
            cand = ptr_i + W'(i);
            if (!found_o && req_i[cand]) begin
                found_o = 1'b1;
                idx_o   = cand;
            end
        end
    end

endmodule

// File: rtl/wr_arbiter.sv
// Packet-locked round-robin arbiter sharing the write path between the ingress ports.
module wr_arbiter
    import hydra_pkg::*;
(
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic     [NUM_PORTS-1:0]          req_vld,
    input  logic     [NUM_PORTS-1:0]          req_last,
    input  logic     [NUM_PORTS-1:0][DATA_W-1:0] req_data,
    input  port_id_t [NUM_PORTS-1:0]          req_dest,
    input  prior_t   [NUM_PORTS-1:0]          req_prior,
    output logic     [NUM_PORTS-1:0]          req_rdy,
    output logic                              out_vld,
    input  logic                              out_rdy,
    output logic     [DATA_W-1:0]             out_data,
    output port_id_t                          out_src,
    output port_id_t                          out_dest,
    output prior_t                            out_prior,
    output logic                              out_last,
    output idx_t                              out_idx,
    output logic                              overflow_err
);

    arb_state_e state_q, state_d;
    port_id_t   rr_ptr_q, rr_ptr_d;
    port_id_t   lock_port_q, lock_port_d;
    idx_t       word_cnt_q, word_cnt_d;
    out_word_t  out_q, out_d;
    logic       out_vld_q, out_vld_d;
    logic       ovf_q, ovf_d;

    logic     found;
    port_id_t winner;
    port_id_t sel;
    logic     can_load;
    logic     accept;
    logic     forced;

    rr_pick #(
        .N(NUM_PORTS)
    ) u_rr_pick (
        .req_i  (req_vld),
        .ptr_i  (rr_ptr_q),
        .found_o(found),
        .idx_o  (winner)
    );

    always_comb begin
        can_load = !out_vld_q || out_rdy;
        sel      = (state_q == LOCKED) ? lock_port_q : winner;

        // rst_n is active-high here; no grant may leave the reset cycle.
        req_rdy = '0;
        if (!rst_n && can_load) begin
            if (state_q == IDLE) begin
                req_rdy[winner] = found;
            end else begin
                req_rdy[lock_port_q] = req_vld[lock_port_q];
            end
        end
        accept = |req_rdy;
        forced = (state_q == LOCKED) && (word_cnt_q == idx_t'(MAX_WORDS - 1)) && !req_last[sel];

        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        lock_port_d = lock_port_q;
        word_cnt_d  = word_cnt_q;
        out_d       = out_q;
        out_vld_d   = out_vld_q && !out_rdy;
        ovf_d       = 1'b0;

        if (accept) begin
            out_d.data  = req_data[sel];
            out_d.src   = sel;
            out_d.dest  = req_dest[sel];
            out_d.prior = req_prior[sel];
            out_d.last  = req_last[sel] || forced;
            out_d.idx   = (state_q == LOCKED) ? word_cnt_q : '0;
            out_vld_d   = 1'b1;
            ovf_d       = forced;

            if (req_last[sel] || forced) begin
                state_d  = IDLE;
                rr_ptr_d = sel + 1'b1;
            end else if (state_q == IDLE) begin
                state_d     = LOCKED;
                lock_port_d = sel;
                word_cnt_d  = idx_t'(1);
            end else begin
                word_cnt_d = word_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            lock_port_q <= '0;
            word_cnt_q  <= '0;
            out_q       <= '0;
            out_vld_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_port_q <= lock_port_d;
            word_cnt_q  <= word_cnt_d;
            out_q       <= out_d;
            out_vld_q   <= out_vld_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_vld      = out_vld_q;
    assign out_data     = out_q.data;
    assign out_src      = out_q.src;
    assign out_dest     = out_q.dest;
    assign out_prior    = out_q.prior;
    assign out_last     = out_q.last;
    assign out_idx      = out_q.idx;
    assign overflow_err = ovf_q;

endmodule

// File: tb/tb_wr_arbiter.sv
// Bench for wr_arbiter: directed scenarios plus random traffic against a packet-level model.
module tb_wr_arbiter;
    import hydra_pkg::*;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [15:0]            req_vld, req_last, req_rdy;
    logic [15:0][127:0]     req_data;
    logic [15:0][3:0]       req_dest;
    logic [15:0][2:0]       req_prior;
    logic                   out_vld, out_rdy, out_last, overflow_err;
    logic [127:0]           out_data;
    logic [3:0]             out_src, out_dest;
    logic [2:0]             out_prior;
    logic [5:0]             out_idx;

    always #5 clk = ~clk;

    wr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_vld     (req_vld),
        .req_last    (req_last),
        .req_data    (req_data),
        .req_dest    (req_dest),
        .req_prior   (req_prior),
        .req_rdy     (req_rdy),
        .out_vld     (out_vld),
        .out_rdy     (out_rdy),
        .out_data    (out_data),
        .out_src     (out_src),
        .out_dest    (out_dest),
        .out_prior   (out_prior),
        .out_last    (out_last),
        .out_idx     (out_idx),
        .overflow_err(overflow_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    // Packet-level reference: who owns the path, how many words it has sent, where
    // the round-robin search resumes, and what the output register should show.
    bit           m_on = 1'b0;
    bit           m_vld, m_ovf, m_lock, m_last;
    int           m_owner, m_cnt, m_rr, m_src, m_dest, m_prior, m_idx;
    logic [127:0] m_data;

    always @(negedge clk) begin
        logic [15:0] exp_rdy;
        int          g;
        bit          f;
        if (m_on) begin
            chk("out_vld", out_vld, m_vld);
            chk("overflow_err", overflow_err, m_ovf);
            if (m_vld)
                chk("out_word", {out_data, out_src, out_dest, out_prior, out_last, out_idx},
                    {m_data, 4'(m_src), 4'(m_dest), 3'(m_prior), m_last, 6'(m_idx)});
        end
        exp_rdy = '0;
        g = -1;
        if (!rst_n && m_on && (!m_vld || out_rdy)) begin
            if (!m_lock) begin
                for (int i = 0; i < 16; i++)
                    if (g < 0 && req_vld[(m_rr + i) % 16]) g = (m_rr + i) % 16;
            end else if (req_vld[m_owner]) begin
                g = m_owner;
            end
            if (g >= 0) exp_rdy[g] = 1'b1;
        end
        if (rst_n || m_on) chk("req_rdy", req_rdy, exp_rdy);

        if (rst_n) begin
            m_on = 1'b1; m_vld = 0; m_ovf = 0; m_lock = 0; m_last = 0;
            m_owner = 0; m_cnt = 0; m_rr = 0; m_src = 0; m_dest = 0; m_prior = 0;
            m_idx = 0; m_data = '0;
        end else if (m_on) begin
            m_ovf = 1'b0;
            if (g >= 0) begin
                f       = m_lock && (m_cnt == int'(MAX_WORDS) - 1) && !req_last[g];
                m_vld   = 1'b1;
                m_data  = req_data[g];
                m_src   = g;
                m_dest  = int'(req_dest[g]);
                m_prior = int'(req_prior[g]);
                m_idx   = m_lock ? m_cnt : 0;
                m_last  = req_last[g] || f;
                m_ovf   = f;
                if (req_last[g] || f) begin
                    m_lock = 1'b0;
                    m_rr   = (g + 1) % 16;
                end else if (!m_lock) begin
                    m_lock = 1'b1; m_owner = g; m_cnt = 1;
                end else begin
                    m_cnt++;
                end
            end else if (out_rdy) begin
                m_vld = 1'b0;
            end
        end
    end

    task automatic set_word(input int p, input logic [127:0] d, input bit last);
        req_data[p]  = d;
        req_last[p]  = last;
        req_dest[p]  = 4'(p ^ 5);
        req_prior[p] = 3'(p);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
    endtask

    logic [15:0]  cont_exp [4] = '{16'h0001, 16'h0020, 16'h8000, 16'h0001};
    int           plen [16];
    int           ppos [16];
    logic [15:0]  acc_v;
    bit           acc;
    int           wi, cyc, n_stall, n_out, n_ovf;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_vld = '0; req_last = '0; req_data = '0; req_dest = '0; req_prior = '0;
        out_rdy = 1'b1; rst_n = 1'b1;
        set_word(3, 128'h33, 1'b1);
        req_vld[3] = 1'b1;
        @(negedge clk); chk("rst_gates_rdy", req_rdy, 16'h0000);
        tick(); req_vld = '0;
        @(negedge clk);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_ovf", overflow_err, 0);
        tick(); rst_n = 1'b0;

        // Single word from port 3.
        set_word(3, 128'hA5, 1'b1); req_vld[3] = 1'b1;
        @(negedge clk); chk("single_rdy", req_rdy, 16'h0008);
        tick(); req_vld = '0;
        @(negedge clk);
        chk("single_vld", out_vld, 1);
        chk("single_src", out_src, 3);
        chk("single_idx", out_idx, 0);
        chk("single_last", out_last, 1);
        // Pointer now 4: port 5 beats port 2, then the scan wraps to 2.
        set_word(2, 128'h2, 1'b1); set_word(5, 128'h5, 1'b1);
        tick(); req_vld = 16'h0024;
        @(negedge clk); chk("rr_after3", req_rdy, 16'h0020);
        tick(); req_vld = 16'h0004;
        @(negedge clk); chk("rr_wrap", req_rdy, 16'h0004);
        tick(); set_word(15, 128'hF, 1'b1); req_vld = 16'h8000;
        tick(); req_vld = '0;

        // Contention among 0, 5, 15 with pointer at 0.
        set_word(0, 128'h10, 1'b1); set_word(5, 128'h15, 1'b1); set_word(15, 128'h1F, 1'b1);
        req_vld = 16'h8021;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); chk($sformatf("contend_%0d", k), req_rdy, cont_exp[k]);
            tick();
        end
        req_vld = '0;

        // Port 2 holds the path for 4 words while port 1 waits.
        for (int k = 0; k < 4; k++) begin
            set_word(2, 128'h200 + 128'(k), k == 3); req_vld[2] = 1'b1;
            if (k > 0) begin set_word(1, 128'h100, 1'b1); req_vld[1] = 1'b1; end
            @(negedge clk);
            chk("lock_rdy", req_rdy, 16'h0004);
            if (k > 0) chk("lock_idx", {out_src, out_idx}, {4'd2, 6'(k - 1)});
            tick();
        end
        req_vld[2] = 1'b0;
        @(negedge clk);
        chk("lock_then_p1", req_rdy, 16'h0002);
        chk("lock_last_word", {out_idx, out_last}, {6'd3, 1'b1});
        tick(); req_vld = '0;

        // Backpressure: 5 stall cycles after word 1 of a 6-word packet.
        wi = 0; cyc = 0; n_stall = 0;
        while (wi < 6 && cyc < 100) begin
            set_word(4, 128'd100 + 128'(wi), wi == 5); req_vld[4] = 1'b1;
            @(negedge clk);
            acc = req_rdy[4];
            if (!out_rdy) begin
                chk("bp_rdy", req_rdy, 16'h0000);
                chk("bp_hold", {out_vld, out_data, out_idx}, {1'b1, 128'd101, 6'd1});
            end
            tick();
            if (acc) wi++;
            cyc++;
            if (wi == 2 && n_stall < 5) begin out_rdy = 1'b0; n_stall++; end
            else out_rdy = 1'b1;
        end
        chk("bp_words", wi, 6);
        req_vld = '0;
        tick();

        // Overflow: 70 unterminated words from port 7.
        wi = 0; n_out = 0; n_ovf = 0; cyc = 0;
        while ((wi < 70 || out_vld) && cyc < 300) begin
            if (wi < 70) begin set_word(7, 128'd700 + 128'(wi), 1'b0); req_vld[7] = 1'b1; end
            else req_vld = '0;
            @(negedge clk);
            acc = req_rdy[7];
            if (overflow_err) n_ovf++;
            if (out_vld) begin
                n_out++;
                if (n_out == 64)
                    chk("ovf_term", {out_idx, out_last, overflow_err}, {6'd63, 1'b1, 1'b1});
                if (n_out == 65)
                    chk("ovf_restart", {out_idx, out_src, out_data}, {6'd0, 4'd7, 128'd764});
            end
            tick();
            if (acc) wi++;
            cyc++;
        end
        chk("ovf_words", n_out, 70);
        chk("ovf_pulses", n_ovf, 1);
        req_vld = '0;
        do_reset();

        // Reset while port 9 is mid-packet.
        wi = 0; cyc = 0;
        while (wi < 2 && cyc < 20) begin
            set_word(9, 128'd900 + 128'(wi), 1'b0); req_vld[9] = 1'b1;
            @(negedge clk); acc = req_rdy[9];
            tick();
            if (acc) wi++;
            cyc++;
        end
        set_word(9, 128'd902, 1'b0);
        rst_n = 1'b1;
        @(negedge clk); chk("rstmid_rdy", req_rdy, 16'h0000);
        tick(); rst_n = 1'b0;
        @(negedge clk);
        chk("rstmid_vld", out_vld, 0);
        chk("rstmid_regrant", req_rdy, 16'h0200);
        tick(); req_vld = '0;
        @(negedge clk); chk("rstmid_restart", {out_idx, out_src, out_data}, {6'd0, 4'd9, 128'd902});
        tick();
        do_reset();

        // Random traffic.
        for (int p = 0; p < 16; p++) begin
            plen[p] = $urandom_range(1, 6);
            ppos[p] = 0;
            req_data[p] = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int c = 0; c < 4000; c++) begin
            for (int p = 0; p < 16; p++) begin
                req_vld[p]   = ($urandom_range(99) < 40);
                req_last[p]  = (ppos[p] == plen[p] - 1);
                req_dest[p]  = 4'($urandom);
                req_prior[p] = 3'($urandom);
            end
            out_rdy = ($urandom_range(99) < 75);
            @(negedge clk);
            acc_v = req_vld & req_rdy;
            tick();
            for (int p = 0; p < 16; p++) begin
                if (acc_v[p]) begin
                    ppos[p]++;
                    if (ppos[p] == plen[p]) begin
                        ppos[p] = 0;
                        plen[p] = ($urandom_range(15) == 0) ? $urandom_range(64, 70)
                                                             : $urandom_range(1, 6);
                    end
                    req_data[p] = {$urandom, $urandom, $urandom, $urandom};
                end
            end
        end
        req_vld = '0; out_rdy = 1'b1;
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
